// File: rtl/edulent_pkg.sv
// Shared definitions for the memory loader: state encoding, width defaults
// and error codes.
package edulent_pkg;

    localparam int ADDR_W_DEF = 8;
    localparam int DATA_W_DEF = 8;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LOAD   = 3'd1,
        ST_CHK    = 3'd2,
        ST_VERIFY = 3'd3,
        ST_DONE   = 3'd4
    } state_t;

    localparam logic [1:0] ERR_NONE     = 2'b00;
    localparam logic [1:0] ERR_CHKSUM   = 2'b01;
    localparam logic [1:0] ERR_READBACK = 2'b10;

endpackage

// File: rtl/mem_loader.sv
// Streams a checksummed payload into memory, then reads it back and compares
// sums while holding the core stalled.
import edulent_pkg::*;

module mem_loader #(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic              i_clk,
    input  logic              i_rstn,
    input  logic              i_start,
    input  logic [ADDR_W-1:0] i_base_addr,
    input  logic [ADDR_W:0]   i_len,
    input  logic [DATA_W-1:0] i_s_data,
    input  logic              i_s_valid,
    output logic              o_s_ready,
    output logic [ADDR_W-1:0] o_mem_addr,
    output logic [DATA_W-1:0] o_mem_data_write,
    output logic              o_mem_write_enable,
    input  logic [DATA_W-1:0] i_mem_data_read,
    output logic              o_busy,
    output logic              o_cpu_hold,
    output logic              o_done,
    output logic              o_error,
    output logic [1:0]        o_err_code
);

    localparam logic [ADDR_W:0] MAX_LEN = {1'b1, {ADDR_W{1'b0}}};
    localparam logic [ADDR_W:0] ONE     = {{ADDR_W{1'b0}}, 1'b1};

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] base_q, base_d;
    logic [ADDR_W:0]   len_q, len_d;
    logic [ADDR_W:0]   idx_q, idx_d;
    logic [DATA_W-1:0] sum_q, sum_d;
    logic [DATA_W-1:0] rb_sum_q, rb_sum_d;
    logic              err_q, err_d;
    logic [1:0]        code_q, code_d;

    logic [ADDR_W:0]   len_clamped;
    logic [DATA_W-1:0] stream_sum;
    logic [DATA_W-1:0] rb_next;
    logic              last_idx;

    assign len_clamped = (i_len > MAX_LEN) ? MAX_LEN : i_len;
    assign stream_sum  = sum_q + i_s_data;
    assign rb_next     = rb_sum_q + i_mem_data_read;
    assign last_idx    = (idx_q == (len_q - ONE));

    assign o_s_ready          = (state_q == ST_LOAD) || (state_q == ST_CHK);
    assign o_mem_write_enable = (state_q == ST_LOAD) && i_s_valid;
    assign o_mem_data_write   = (state_q == ST_LOAD) ? i_s_data : '0;
    assign o_mem_addr         = ((state_q == ST_LOAD) || (state_q == ST_VERIFY))
                                ? base_q + idx_q[ADDR_W-1:0] : '0;
    assign o_busy             = (state_q != ST_IDLE);
    assign o_cpu_hold         = (state_q != ST_IDLE);
    assign o_done             = (state_q == ST_DONE);
    assign o_error            = err_q;
    assign o_err_code         = code_q;

    always_comb begin
        state_d  = state_q;
        base_d   = base_q;
        len_d    = len_q;
        idx_d    = idx_q;
        sum_d    = sum_q;
        rb_sum_d = rb_sum_q;
        err_d    = err_q;
        code_d   = code_q;
        case (state_q)
            ST_IDLE: begin
                if (i_start) begin
                    err_d  = 1'b0;
                    code_d = ERR_NONE;
                    if (i_len == '0) begin
                        state_d = ST_DONE;
                    end else begin
                        base_d   = i_base_addr;
                        len_d    = len_clamped;
                        idx_d    = '0;
                        sum_d    = '0;
                        rb_sum_d = '0;
                        state_d  = ST_LOAD;
                    end
                end
            end
            ST_LOAD: begin
                if (i_s_valid) begin
                    sum_d = stream_sum;
                    idx_d = idx_q + ONE;
                    if (last_idx) state_d = ST_CHK;
                end
            end
            ST_CHK: begin
                if (i_s_valid) begin
                    if (stream_sum != '0) begin
                        err_d  = 1'b1;
                        code_d = ERR_CHKSUM;
                    end
                    idx_d    = '0;
                    rb_sum_d = '0;
                    state_d  = ST_VERIFY;
                end
            end
            ST_VERIFY: begin
                rb_sum_d = rb_next;
                idx_d    = idx_q + ONE;
                if (last_idx) begin
                    // a checksum failure is the root cause, so it keeps its code
                    if ((rb_next != sum_q) && (code_q != ERR_CHKSUM)) begin
                        err_d  = 1'b1;
                        code_d = ERR_READBACK;
                    end
                    state_d = ST_DONE;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            state_q  <= ST_IDLE;
            base_q   <= '0;
            len_q    <= '0;
            idx_q    <= '0;
            sum_q    <= '0;
            rb_sum_q <= '0;
            err_q    <= 1'b0;
            code_q   <= ERR_NONE;
        end else begin
            state_q  <= state_d;
            base_q   <= base_d;
            len_q    <= len_d;
            idx_q    <= idx_d;
            sum_q    <= sum_d;
            rb_sum_q <= rb_sum_d;
            err_q    <= err_d;
            code_q   <= code_d;
        end
    end

endmodule

// File: tb/tb_mem_loader.sv
// Scoreboard bench for mem_loader: expected writes, readback addresses and
// completion status are queued by the stimulus and popped by a monitor.
module tb_mem_loader;

    logic       i_clk = 1'b0;
    logic       i_rstn = 1'b0;
    logic       i_start = 1'b0;
    logic [7:0] i_base_addr = '0;
    logic [8:0] i_len = '0;
    logic [7:0] i_s_data = '0;
    logic       i_s_valid = 1'b0;
    logic       o_s_ready;
    logic [7:0] o_mem_addr;
    logic [7:0] o_mem_data_write;
    logic       o_mem_write_enable;
    logic [7:0] i_mem_data_read;
    logic       o_busy, o_cpu_hold, o_done, o_error;
    logic [1:0] o_err_code;

    logic [7:0] mem [256];
    logic [7:0] sb [512];
    bit         corrupt = 1'b0;
    int         cyc = 0;
    int         checks = 0;
    int         failures = 0;
    int         n_writes = 0;

    logic [15:0] wq [$];
    logic [7:0]  rq [$];
    logic [2:0]  dq [$];

    mem_loader #(.ADDR_W(8), .DATA_W(8)) dut (
        .i_clk              (i_clk),
        .i_rstn             (i_rstn),
        .i_start            (i_start),
        .i_base_addr        (i_base_addr),
        .i_len              (i_len),
        .i_s_data           (i_s_data),
        .i_s_valid          (i_s_valid),
        .o_s_ready          (o_s_ready),
        .o_mem_addr         (o_mem_addr),
        .o_mem_data_write   (o_mem_data_write),
        .o_mem_write_enable (o_mem_write_enable),
        .i_mem_data_read    (i_mem_data_read),
        .o_busy             (o_busy),
        .o_cpu_hold         (o_cpu_hold),
        .o_done             (o_done),
        .o_error            (o_error),
        .o_err_code         (o_err_code)
    );

    always #5 i_clk = ~i_clk;

    always @(posedge i_clk) cyc <= cyc + 1;

    always @(posedge i_clk) begin
        if (o_mem_write_enable) mem[o_mem_addr] <= o_mem_data_write;
    end

    assign i_mem_data_read = mem[o_mem_addr] ^ ((corrupt && o_mem_addr == 8'h11) ? 8'hFF : 8'h00);

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Monitor: VERIFY is the only busy state with o_s_ready low and o_done low.
    always @(negedge i_clk) begin
        if (i_rstn) begin
            if (o_mem_write_enable) begin
                n_writes++;
                if (wq.size() == 0) begin
                    checks++; failures++;
                    $display("FAIL write_unexpected actual=%h:%h required=none", o_mem_addr, o_mem_data_write);
                end else begin
                    chk("write_addr_data", {o_mem_addr, o_mem_data_write}, wq.pop_front());
                end
            end
            if (o_busy && !o_s_ready && !o_done) begin
                if (rq.size() == 0) begin
                    checks++; failures++;
                    $display("FAIL verify_unexpected actual=%h required=none", o_mem_addr);
                end else begin
                    chk("verify_addr", o_mem_addr, rq.pop_front());
                end
            end
            if (o_done) begin
                if (dq.size() == 0) begin
                    checks++; failures++;
                    $display("FAIL done_unexpected actual=%b required=none", o_done);
                end else begin
                    chk("done_err_code", {o_error, o_err_code}, dq.pop_front());
                end
            end
        end
    end

    task automatic feed_byte(input logic [7:0] d, input bit gaps, output bit ok);
        int guard;
        bit acc;
        if (gaps) begin
            repeat ($urandom_range(0, 3)) begin
                i_s_valid = 1'b0;
                @(posedge i_clk); #1;
            end
        end
        i_s_data  = d;
        i_s_valid = 1'b1;
        acc = 1'b0;
        guard = 0;
        while (!acc && guard < 20) begin
            @(negedge i_clk);
            acc = o_s_ready;
            @(posedge i_clk); #1;
            guard++;
        end
        ok = acc;
    endtask

    task automatic run_load(input logic [7:0] base, input logic [8:0] len, input logic [7:0] cks,
                            input bit gaps, input logic exp_err, input logic [1:0] exp_code,
                            input int exp_lat);
        int  n;
        int  start_cyc;
        bit  ok;
        bit  found;
        logic [7:0] a;
        n = (len > 9'd256) ? 256 : int'(len);
        for (int i = 0; i < n; i++) begin
            a = base + 8'(i);
            wq.push_back({a, sb[i]});
            rq.push_back(a);
        end
        dq.push_back({exp_err, exp_code});
        @(posedge i_clk); #1;
        i_start = 1'b1; i_base_addr = base; i_len = len;
        start_cyc = cyc;
        @(posedge i_clk); #1;
        i_start = 1'b0;
        if (n > 0) begin
            for (int k = 0; k <= n; k++) begin
                feed_byte((k < n) ? sb[k] : cks, gaps, ok);
                if (!ok) begin
                    chk("stream_accept_timeout", 0, 1);
                    break;
                end
            end
        end
        i_s_valid = 1'b0;
        found = 1'b0;
        for (int g = 0; g < 700 && !found; g++) begin
            @(negedge i_clk);
            found = o_done;
        end
        chk("done_seen", found, 1);
        if (found && exp_lat >= 0) chk("done_latency", cyc - start_cyc, exp_lat);
        @(posedge i_clk); #1;
    endtask

    initial begin
        int  w0;
        bit  ok;

        repeat (3) @(posedge i_clk);
        #1;
        chk("rst_busy", o_busy, 0);
        chk("rst_hold", o_cpu_hold, 0);
        chk("rst_ready", o_s_ready, 0);
        chk("rst_we", o_mem_write_enable, 0);
        chk("rst_done", o_done, 0);
        chk("rst_err", {o_error, o_err_code}, 0);
        chk("rst_addr", o_mem_addr, 0);
        @(negedge i_clk);
        i_rstn = 1'b1;

        // basic load, good checksum: 0x19+0x01+0x50+0x96 = 0x100
        sb[0] = 8'h19; sb[1] = 8'h01; sb[2] = 8'h50;
        run_load(8'h10, 9'd3, 8'h96, 1'b0, 1'b0, 2'b00, 8);
        chk("mem_10", mem[8'h10], 8'h19);
        chk("mem_11", mem[8'h11], 8'h01);
        chk("mem_12", mem[8'h12], 8'h50);

        run_load(8'h10, 9'd3, 8'h00, 1'b0, 1'b1, 2'b01, 8);
        repeat (3) @(posedge i_clk);
        #1;
        chk("err_sticky", {o_error, o_err_code}, 3'b101);
        chk("idle_busy", o_busy, 0);

        // wrap: sum 0xA1+0xB2+0xC3+0xD4 = 0xEA, checksum 0x16
        sb[0] = 8'hA1; sb[1] = 8'hB2; sb[2] = 8'hC3; sb[3] = 8'hD4;
        run_load(8'hFE, 9'd4, 8'h16, 1'b0, 1'b0, 2'b00, 10);
        chk("mem_ff", mem[8'hFF], 8'hB2);
        chk("mem_00", mem[8'h00], 8'hC3);
        chk("mem_01", mem[8'h01], 8'hD4);

        sb[0] = 8'h19; sb[1] = 8'h01; sb[2] = 8'h50;
        corrupt = 1'b1;
        run_load(8'h10, 9'd3, 8'h96, 1'b0, 1'b1, 2'b10, 8);
        corrupt = 1'b0;

        w0 = n_writes;
        run_load(8'h40, 9'd0, 8'h00, 1'b0, 1'b0, 2'b00, 1);
        chk("len0_no_writes", n_writes - w0, 0);

        // clamp: bytes 0..255 sum to 0x80, checksum 0x80
        for (int i = 0; i < 256; i++) sb[i] = 8'(i);
        w0 = n_writes;
        run_load(8'h00, 9'd300, 8'h80, 1'b0, 1'b0, 2'b00, 514);
        chk("len300_writes", n_writes - w0, 256);

        // reset after the second byte
        sb[0] = 8'h11; sb[1] = 8'h22; sb[2] = 8'h33; sb[3] = 8'h44;
        wq.push_back({8'h20, 8'h11});
        wq.push_back({8'h21, 8'h22});
        @(posedge i_clk); #1;
        i_start = 1'b1; i_base_addr = 8'h20; i_len = 9'd4;
        @(posedge i_clk); #1;
        i_start = 1'b0;
        for (int k = 0; k < 2; k++) begin
            feed_byte(sb[k], 1'b0, ok);
            if (!ok) chk("midrst_accept_timeout", 0, 1);
        end
        i_s_valid = 1'b0;
        i_rstn = 1'b0;
        #1;
        chk("midrst_busy", o_busy, 0);
        chk("midrst_hold", o_cpu_hold, 0);
        chk("midrst_ready", o_s_ready, 0);
        chk("midrst_err", {o_error, o_err_code}, 0);
        @(negedge i_clk);
        i_rstn = 1'b1;
        run_load(8'h20, 9'd4, 8'h56, 1'b0, 1'b0, 2'b00, 10);

        // random valid gaps: 1+2+3+4+5 = 0x0F, checksum 0xF1
        for (int i = 0; i < 5; i++) sb[i] = 8'(i + 1);
        w0 = n_writes;
        run_load(8'h80, 9'd5, 8'hF1, 1'b1, 1'b0, 2'b00, -1);
        chk("gaps_writes", n_writes - w0, 5);

        repeat (2) @(posedge i_clk);
        #1;
        chk("wq_empty", wq.size(), 0);
        chk("rq_empty", rq.size(), 0);
        chk("dq_empty", dq.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
